// File: rtl/nlx_sram_req_ctrl_if.sv
// rtl/nlx_sram_req_ctrl_if.sv - command, response and SRAM pin bundle for nlx_sram_req_ctrl
interface nlx_sram_req_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int BW = DW / 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [BW-1:0] req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [BW-1:0] sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          busy;

  modport master (
    output req_valid, req_write, req_be, req_addr, req_wdata, rsp_ready, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, sram_we, sram_addr, sram_wdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_be, req_addr, req_wdata, rsp_ready, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, sram_we, sram_addr, sram_wdata, busy
  );
endinterface

// File: rtl/nlx_sram_req_ctrl.sv
// rtl/nlx_sram_req_ctrl.sv - SRAM request front-end with credit-limited read response FIFO
// Optional address range check enabled by NLX_SRAM_ADDR_CHK_EN.
module nlx_sram_req_ctrl #(
  parameter int            AW        = 16,
  parameter int            DW        = 32,
  parameter int            RD_LAT    = 1,
  parameter int            RSP_DEPTH = 4,
  parameter logic [AW-1:0] ADDR_MAX  = '1
) (
  input logic            clk,
  input logic            rst,
  nlx_sram_req_ctrl_if.slave bus
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic              accept;
  logic              rd_acc;
  logic              oob;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [DW-1:0]     push_data;
  logic [CW-1:0]     credit;
  logic              rd_issue;
  logic              rd_issue_err;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_e;
  logic [DW-1:0]     fifo_d [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fifo_e;
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;

  assign bus.req_ready = (credit != '0);
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_acc        = accept && !bus.req_write;

`ifdef NLX_SRAM_ADDR_CHK_EN
  assign oob = (bus.req_addr > ADDR_MAX);
`else
  logic unused_addr_max;
  assign oob             = 1'b0;
  assign unused_addr_max = ^ADDR_MAX;
`endif

  // Out-of-range commands leave the address pins untouched and never strobe a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sram_we    <= '0;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= '0;
    end else begin
      bus.sram_we <= (accept && bus.req_write && !oob) ? bus.req_be : '0;
      if (accept) begin
        bus.sram_wdata <= bus.req_wdata;
        if (!oob) bus.sram_addr <= bus.req_addr;
      end
    end
  end

  // rd_issue marks the cycle the read address sits on the pins; pipe_v then counts RD_LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_issue     <= 1'b0;
      rd_issue_err <= 1'b0;
      pipe_v       <= '0;
      pipe_e       <= '0;
    end else begin
      rd_issue     <= rd_acc;
      rd_issue_err <= rd_acc && oob;
      pipe_v[0]    <= rd_issue;
      pipe_e[0]    <= rd_issue_err;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
      end
    end
  end

  assign push      = pipe_v[RD_LAT-1];
  assign push_data = pipe_e[RD_LAT-1] ? '0 : bus.sram_rdata;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop       = !empty && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_d[wr_ptr[PW-1:0]] <= push_data;
      fifo_e[wr_ptr[PW-1:0]] <= pipe_e[RD_LAT-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Head is gated while empty so stale entries never show on the response bus.
  assign bus.rsp_valid = !empty;
  assign bus.rsp_rdata = empty ? '0 : fifo_d[rd_ptr[PW-1:0]];
  assign bus.rsp_err   = empty ? 1'b0 : fifo_e[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= CW'(RSP_DEPTH);
    end else begin
      case ({rd_acc, pop})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   credit <= credit + CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  assign bus.busy = rd_issue || (|pipe_v) || !empty;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_nlx_sram_req_ctrl.sv
// tb/tb_nlx_sram_req_ctrl.sv - randomized self-checking bench for nlx_sram_req_ctrl
module tb_nlx_sram_req_ctrl;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;
`ifdef NLX_SRAM_ADDR_CHK_EN
  localparam logic [15:0] AMAX = 16'h00FF;
`else
  localparam logic [15:0] AMAX = 16'hFFFF;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   passed;
  int   total;
  int   fails;

  nlx_sram_req_ctrl_if #(.AW(16), .DW(32)) bus ();

  nlx_sram_req_ctrl #(
    .AW(16), .DW(32), .RD_LAT(RD_LAT), .RSP_DEPTH(DEPTH), .ADDR_MAX(AMAX)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sram_mem [65536];
  logic [31:0] ref_mem  [65536];
  logic [31:0] rd_pipe  [RD_LAT];

  always @(posedge clk) begin
    rd_pipe[0] <= sram_mem[bus.sram_addr];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    for (int b = 0; b < 4; b++)
      if (bus.sram_we[b]) sram_mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
  end
  assign bus.sram_rdata = rd_pipe[RD_LAT-1];

  logic [32:0] exp_q [$];
  logic [32:0] got_q [$];
  int          got_cyc [$];
  logic [15:0] last_addr;

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      got_q.push_back({bus.rsp_err, bus.rsp_rdata});
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_oob(input logic [15:0] a);
`ifdef NLX_SRAM_ADDR_CHK_EN
    return a > AMAX;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command and waits for its accept; n counts edges until accepted.
  task automatic issue(input logic wr, input logic [3:0] be, input logic [15:0] a,
                       input logic [31:0] d, output int n);
    logic rdy;
    logic o;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_be    = be;
    bus.req_addr  = a;
    bus.req_wdata = d;
    do begin
      rdy = bus.req_ready;
      tick();
      n++;
      if (!rdy && n > 40) bus.rsp_ready = 1'b1;
    end while (!rdy && n < 200);
    if (!rdy) chk("accept_timeout", 64'(n), 64'(0));
    o = is_oob(a);
    if (wr) begin
      if (!o)
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end else begin
      exp_q.push_back(o ? {1'b1, 32'h0} : {1'b0, ref_mem[a]});
    end
    if (!o) last_addr = a;
    chk("pin_we", 64'(bus.sram_we), 64'((wr && !o) ? be : 4'h0));
    chk("pin_addr", 64'(bus.sram_addr), 64'(last_addr));
    chk("pin_wdata", 64'(bus.sram_wdata), 64'(d));
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    tick();
    chk("idle_we", 64'(bus.sram_we), 64'(0));
    chk("idle_addr_hold", 64'(bus.sram_addr), 64'(last_addr));
  endtask

  task automatic drain();
    int n;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 500) begin
      tick();
      n++;
    end
    tick();
    chk("rsp_count", 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk("rsp_data_err", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(0));
    chk({tag, "_sram_we"}, 64'(bus.sram_we), 64'(0));
    chk({tag, "_sram_addr"}, 64'(bus.sram_addr), 64'(0));
    chk({tag, "_sram_wdata"}, 64'(bus.sram_wdata), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int n;
    int w;
    logic [15:0] a;
    cyc = 0; passed = 0; total = 0; fails = 0;
    last_addr = '0;
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
      ref_mem[i]  = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
    end
    for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_be = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst");
    tick(); tick();
    rst = 1'b0;
    tick();

    // write then read back with exact latency
    issue(1'b1, 4'hF, 16'h0010, 32'hDEAD_BEEF, n);
    chk("wr_we_full", 64'(bus.sram_we), 64'(4'hF));
    idle();
    issue(1'b0, 4'h0, 16'h0010, 32'h0, n);
    bus.req_valid = 1'b0;
    for (int k = 0; k < RD_LAT; k++) begin
      tick();
      chk("lat_not_yet", 64'(bus.rsp_valid), 64'(0));
    end
    tick();
    chk("lat_valid", 64'(bus.rsp_valid), 64'(1));
    chk("lat_rdata", 64'(bus.rsp_rdata), 64'(32'hDEAD_BEEF));
    chk("lat_err", 64'(bus.rsp_err), 64'(0));
    drain();

    // partial byte-enable merge
    issue(1'b1, 4'hF, 16'h0020, 32'hFFFF_FFFF, n);
    issue(1'b1, 4'b0101, 16'h0020, 32'h1122_3344, n);
    issue(1'b0, 4'h0, 16'h0020, 32'h0, n);
    bus.req_valid = 1'b0;
    for (int k = 0; k < RD_LAT + 3; k++) tick();
    chk("partial_rdata", 64'(got_q.size() > 0 ? got_q[0][31:0] : 32'h0), 64'(32'hFF22_FF44));
    drain();

    // credit exhaustion and return
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, 4'h0, 16'(8'h40 + i), 32'h0, n);
      chk("credit_accept_edges", 64'(n), 64'(1));
    end
    chk("credit_stall", 64'(bus.req_ready), 64'(0));
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0044;
    tick(); tick(); tick();
    chk("credit_stall_held", 64'(bus.req_ready), 64'(0));
    bus.rsp_ready = 1'b1;
    issue(1'b0, 4'h0, 16'h0044, 32'h0, n);
    chk("credit_return_edges", 64'(n), 64'(2));
    drain();

    // asynchronous reset mid-operation
    bus.rsp_ready = 1'b0;
    issue(1'b0, 4'h0, 16'h0050, 32'h0, n);
    bus.req_valid = 1'b0;
    w = 0;
    while (!bus.rsp_valid && w < 20) begin tick(); w++; end
    issue(1'b0, 4'h0, 16'h0051, 32'h0, n);
    issue(1'b0, 4'h0, 16'h0052, 32'h0, n);
    bus.req_valid = 1'b0;
    chk("pre_rst_busy", 64'(bus.busy), 64'(1));
    chk("pre_rst_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    last_addr = '0;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < RD_LAT + 3; k++) begin
      tick();
      chk("post_rst_no_rsp", 64'(bus.rsp_valid), 64'(0));
    end
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, 4'h0, 16'(8'h60 + i), 32'h0, n);
      chk("post_rst_credit_edges", 64'(n), 64'(1));
    end
    chk("post_rst_credit_empty", 64'(bus.req_ready), 64'(0));
    drain();

    // back-to-back reads, full throughput
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 4'h0, 16'(8'h80 + 3 * i), 32'(i), n);
      chk("b2b_accept_edges", 64'(n), 64'(1));
    end
    bus.req_valid = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'(1));
    w = 0;
    while (got_q.size() < 8 && w < 50) begin tick(); w++; end
    chk("b2b_busy_clear", 64'(bus.busy), 64'(0));
    for (int i = 1; i < 8 && i < got_cyc.size(); i++)
      chk("b2b_consecutive", 64'(got_cyc[i] - got_cyc[0]), 64'(i));
    drain();

    // range check boundary
    issue(1'b0, 4'h0, 16'h0100, 32'h0, n);
    issue(1'b1, 4'hF, 16'h0100, 32'hCAFE_F00D, n);
    issue(1'b0, 4'h0, 16'h00FF, 32'h0, n);
    drain();

    // randomized mix against the reference model
    for (int i = 0; i < 300; i++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(200, 400)) : 16'($urandom_range(0, 31));
        issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, n);
      end
      while (got_q.size() > 0 && exp_q.size() > 0)
        chk("rand_rsp", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    end
    drain();
    chk("final_idle_busy", 64'(bus.busy), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
